// File: rtl/adder_bist.sv
// adder_bist: self-test generator and checker for WIDTH-bit adders.
// Drives directed + LFSR vectors and compares against a registered golden add.
module adder_bist #(
  parameter int          WIDTH       = 32,
  parameter int          NUM_VECTORS = 1024,
  parameter logic [31:0] SEED_A      = 32'hACE1_1234,
  parameter logic [31:0] SEED_B      = 32'h1357_9BDF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin
);

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_d;

  logic [15:0]      idx, nidx;
  logic [31:0]      la, lb;
  logic [WIDTH-1:0] gs;
  logic             gc;
  logic [WIDTH-1:0] na, nb;
  logic             ncin, rnd;
  logic             load, step, finish, mismatch;
  logic [WIDTH:0]   gold_d;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : 32'h0);
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and run control strobes
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (idx == LAST) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next vector; the first pseudo-random vector uses the seeds themselves
  always_comb begin
    nidx = load ? 16'd0 : idx + 16'd1;
    na   = '0;
    nb   = '0;
    ncin = 1'b0;
    rnd  = 1'b0;
    unique case (1'b1)
      (nidx == 16'd0): ;
      (nidx == 16'd1): begin
        na   = '1;
        ncin = 1'b1;
      end
      (nidx == 16'd2): begin
        na   = '1;
        nb   = '1;
        ncin = 1'b1;
      end
      (nidx == 16'd3): begin
        na   = {WIDTH/2{2'b10}};
        nb   = {WIDTH/2{2'b01}};
        ncin = 1'b1;
      end
      default: begin
        na   = la[WIDTH-1:0];
        nb   = lb[WIDTH-1:0];
        ncin = la[0] ^ lb[0];
        rnd  = 1'b1;
      end
    endcase
    gold_d = {1'b0, na} + {1'b0, nb}
           + {{WIDTH{1'b0}}, ncin};
  end

  // Case-inequality so X/Z from the adder counts as a failure
  assign mismatch = (state == RUN)
                  && ({cout, sum} !== {gc, gs});

  // Datapath: vector/golden registers, error tally, first-fail capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a         <= '0;
      b         <= '0;
      cin       <= 1'b0;
      gs        <= '0;
      gc        <= 1'b0;
      idx       <= '0;
      la        <= SEED_A;
      lb        <= SEED_B;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_cin  <= 1'b0;
    end else if (load) begin
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_cin  <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      la        <= SEED_A;
      lb        <= SEED_B;
      idx       <= '0;
      a         <= na;
      b         <= nb;
      cin       <= ncin;
      {gc, gs}  <= gold_d;
      busy      <= 1'b1;
    end else if (state == RUN) begin
      if (mismatch) begin
        if (err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
        if (err_count == 16'd0) begin
          fail_a   <= a;
          fail_b   <= b;
          fail_cin <= cin;
        end
      end
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == 16'd0) && !mismatch;
      end
      if (step) begin
        idx      <= nidx;
        a        <= na;
        b        <= nb;
        cin      <= ncin;
        {gc, gs} <= gold_d;
        if (rnd) begin
          la <= lfsr_next(la);
          lb <= lfsr_next(lb);
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: scoreboard bench for adder_bist with a fault-injectable adder.
// Vector and result expectations are queued by stimulus, checked by a monitor.
module tb_adder_bist;

  localparam int N  = 1024;
  localparam int N8 = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a, b, sum, fail_a, fail_b;
  logic        cin, cout, busy, done, pass, fail_cin;
  logic [15:0] err_count;

  logic        start8 = 1'b0;
  logic [7:0]  a8, b8, sum8, fa8, fb8;
  logic        cin8, cout8, busy8, done8, pass8, fc8;
  logic [15:0] err8;

  int mode = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [64:0] fvec;
  } res_t;

  logic [64:0] vec_q[$];
  res_t        res_q[$];

  always #5 clk = ~clk;

  adder_bist dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_a(fail_a),
    .fail_b(fail_b), .fail_cin(fail_cin)
  );

  adder_bist #(.WIDTH(8), .NUM_VECTORS(N8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .a(a8), .b(b8), .cin(cin8), .sum(sum8),
    .cout(cout8), .busy(busy8), .done(done8),
    .pass(pass8), .err_count(err8), .fail_a(fa8),
    .fail_b(fb8), .fail_cin(fc8)
  );

  // Adder under test with selectable stuck faults
  always_comb begin
    logic [32:0] t;
    t = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    sum  = t[31:0];
    cout = t[32];
    if (mode == 1) sum[5] = 1'b0;
    if (mode == 2) cout = 1'b0;
  end

  assign {cout8, sum8} = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};

  function automatic void chk(input string nm,
                              input logic [64:0] act,
                              input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] lnext(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Queue expected vectors and the run result for adder fault mode m
  task automatic build(input int m);
    logic [31:0] la, lb, va, vb;
    logic        vc, bad;
    logic [32:0] t;
    res_t        r;
    la = 32'hACE1_1234;
    lb = 32'h1357_9BDF;
    r.err  = 0;
    r.fvec = '0;
    for (int i = 0; i < N; i++) begin
      case (i)
        0: begin va = 32'h0; vb = 32'h0; vc = 0; end
        1: begin va = 32'hFFFF_FFFF; vb = 32'h0; vc = 1; end
        2: begin va = 32'hFFFF_FFFF; vb = 32'hFFFF_FFFF; vc = 1; end
        3: begin va = 32'hAAAA_AAAA; vb = 32'h5555_5555; vc = 1; end
        default: begin
          va = la; vb = lb; vc = la[0] ^ lb[0];
          la = lnext(la); lb = lnext(lb);
        end
      endcase
      vec_q.push_back({va, vb, vc});
      t = {1'b0, va} + {1'b0, vb} + {32'd0, vc};
      bad = (m == 1 && t[5]) || (m == 2 && t[32]);
      if (bad) begin
        if (r.err == 0) r.fvec = {va, vb, vc};
        r.err++;
      end
    end
    r.pass = (r.err == 0);
    res_q.push_back(r);
  endtask

  // Monitor: check each presented vector and each finished run
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (reset && busy) begin
      if (vec_q.size() == 0) begin
        chk("vec_underflow", 65'd1, 65'd0);
      end else begin
        chk("vector", {a, b, cin}, vec_q.pop_front());
      end
    end
    if (reset && done && !done_q) begin
      if (res_q.size() == 0) begin
        chk("res_underflow", 65'd1, 65'd0);
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("pass", 65'(pass), 65'(r.pass));
        chk("err_count", 65'(err_count), 65'(r.err));
        chk("fail_vec", {fail_a, fail_b, fail_cin}, r.fvec);
      end
    end
    done_q = done;
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < N + 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 65'(n), 65'(N));
  endtask

  task automatic run(input int m);
    mode = m;
    build(m);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("done_latency");
    @(negedge clk);
    @(negedge clk);
    chk("queues_empty", 65'(vec_q.size() + res_q.size()), 65'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        {busy, done, pass, err_count, cin, fail_cin, fail_a},
        65'd0);
    chk("reset_ab", {a, b}, 65'd0);
    @(negedge clk);
    reset = 1'b1;

    // Ideal, stuck sum bit 5, cout tied low
    run(0);
    run(1);
    run(2);

    // Reset mid-run at vector 300, then identical rerun
    mode = 0;
    build(0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #2 reset = 1'b0;
    vec_q.delete();
    res_q.delete();
    #1;
    chk("abort_flags",
        {busy, done, pass, err_count, cin, fail_cin, fail_a},
        65'd0);
    chk("abort_ab", {a, b, fail_b}, 65'd0);
    @(negedge clk);
    reset = 1'b1;
    run(0);

    // start held through RUN and into DONE: immediate rerun, errors cleared
    mode = 1;
    build(1);
    build(0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("held_latency");
    mode = 0;
    @(posedge clk);
    #1;
    chk("rerun_busy", {busy, done, err_count}, {1'b1, 1'b0, 16'd0});
    start = 1'b0;
    wait_done("rerun_latency");
    @(negedge clk);
    @(negedge clk);
    chk("queues_empty2", 65'(vec_q.size() + res_q.size()), 65'd0);

    // 8-bit build with an ideal adder
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0;
    while (!done8 && n < N8 + 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w8_latency", 65'(n), 65'(N8));
    chk("w8_result", {pass8, err8, fa8, fb8, fc8},
        {1'b1, 16'd0, 8'd0, 8'd0, 1'b0});
    chk("w8_busy", 65'(busy8), 65'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
